fifo_rd_unpacker: RTL

- Reader end of the 16-bit-in / wide-out asynchronous FIFO.
- Pops IN_W-bit words from the FIFO read port, which has 1-cycle read latency and no output register.
- Splits each word into IN_W/OUT_W narrow beats and emits them on a valid/ready stream toward the video/DDR consumer.
- A one-word prefetch buffer gives full throughput: one beat per clock while out_ready is held high.

---
 rtl/fifo_unpack_pkg.sv | 29 ++
 rtl/unpack_word_buf.sv | 82 ++++++++
 rtl/fifo_rd_unpacker.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fifo_unpack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_unpack_pkg
// Purpose  : Shared types and helpers for the FIFO read-side word unpacker.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_unpack_pkg;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    function automatic int calc_ratio(input int in_w, input int out_w);
        return (out_w > 0) ? (in_w / out_w) : 0;
    endfunction

    function automatic int calc_cnt_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    // Maps the beat counter to the slice index; MSB-first walks from the top slice down.
    function automatic int beat_slice(input int cnt, input int ratio, input int msb_first);
        return (msb_first != 0) ? (ratio - 1 - cnt) : cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/unpack_word_buf.sv
`default_nettype none
// ============================================================================
// Module   : unpack_word_buf
// Purpose  : Two-entry cur/nxt word buffer; occupancy tracked as an FSM.
// Revision : 1.0 - initial release
// ============================================================================
module unpack_word_buf
    import fifo_unpack_pkg::*;
#(
    parameter int IN_W = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            land,
    input  logic [IN_W-1:0] land_data,
    input  logic            retire,
    output logic [IN_W-1:0] cur_word,
    output logic            cur_vld,
    output logic            nxt_vld
);

    buf_state_t      r_state;
    buf_state_t      w_state_nxt;
    logic [IN_W-1:0] r_cur;
    logic [IN_W-1:0] r_nxt;
    logic [IN_W-1:0] w_cur_d;
    logic [IN_W-1:0] w_nxt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BUF_EMPTY;
            r_cur   <= '0;
            r_nxt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_d;
            r_nxt   <= w_nxt_d;
        end
    end

    // A landing word never meets FULL without a retire: the pop rule forbids it.
    always_comb begin
        w_state_nxt = r_state;
        w_cur_d     = r_cur;
        w_nxt_d     = r_nxt;
        case (r_state)
            BUF_EMPTY: begin
                if (land) begin
                    w_state_nxt = BUF_ONE;
                    w_cur_d     = land_data;
                end
            end
            BUF_ONE: begin
                if (retire && land) begin
                    w_cur_d = land_data;
                end else if (retire) begin
                    w_state_nxt = BUF_EMPTY;
                end else if (land) begin
                    w_state_nxt = BUF_FULL;
                    w_nxt_d     = land_data;
                end
            end
            BUF_FULL: begin
                if (retire) begin
                    w_cur_d = r_nxt;
                    if (land) begin
                        w_nxt_d = land_data;
                    end else begin
                        w_state_nxt = BUF_ONE;
                    end
                end
            end
            default: w_state_nxt = BUF_EMPTY;
        endcase
    end

    assign cur_word = r_cur;
    assign cur_vld  = (r_state != BUF_EMPTY);
    assign nxt_vld  = (r_state == BUF_FULL);

endmodule
`default_nettype wire

// File: rtl/fifo_rd_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_unpacker
// Purpose  : Pops wide FIFO words and streams them out as narrow beats.
//            Define UNPACK_STALL_CNT_EN to add stall_cnt/starve_cnt outputs.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_unpacker
    import fifo_unpack_pkg::*;
#(
    parameter int IN_W      = 64,
    parameter int OUT_W     = 16,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             fifo_rd_en,
    input  logic [IN_W-1:0]  fifo_rd_data,
    input  logic             fifo_rd_empty,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
`ifdef UNPACK_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt,
    output logic [15:0]      starve_cnt
`endif
);

    localparam int RATIO = calc_ratio(IN_W, OUT_W);
    localparam int CNT_W = calc_cnt_w(RATIO);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

    generate
        if (RATIO < 2 || (IN_W % OUT_W) != 0) begin : g_bad_cfg
            $error("fifo_rd_unpacker: IN_W must be a multiple of OUT_W with IN_W/OUT_W >= 2");
        end
    endgenerate

    logic [IN_W-1:0]  w_cur_word;
    logic             w_cur_vld;
    logic             w_nxt_vld;
    logic             r_inflight;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [CNT_W-1:0] w_sel;
    logic             w_xfer;
    logic             w_retire;
    logic [1:0]       w_occ;
    logic [OUT_W-1:0] w_beats [RATIO];

    unpack_word_buf #(
        .IN_W (IN_W)
    ) u_word_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .land      (r_inflight),
        .land_data (fifo_rd_data),
        .retire    (w_retire),
        .cur_word  (w_cur_word),
        .cur_vld   (w_cur_vld),
        .nxt_vld   (w_nxt_vld)
    );

    assign w_xfer   = w_cur_vld & out_ready;
    assign w_retire = w_xfer & (r_beat_cnt == LAST_BEAT);

    // The slot freed by this cycle's retire already counts as free.
    assign w_occ      = {1'b0, w_cur_vld} + {1'b0, w_nxt_vld} + {1'b0, r_inflight} - {1'b0, w_retire};
    assign fifo_rd_en = rst_n & ~fifo_rd_empty & (w_occ < 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_inflight <= fifo_rd_en;
            if (w_xfer) begin
                r_beat_cnt <= w_retire ? '0 : r_beat_cnt + CNT_W'(1);
            end
        end
    end

    generate
        for (genvar g = 0; g < RATIO; g++) begin : g_slice
            assign w_beats[g] = w_cur_word[g*OUT_W +: OUT_W];
        end
    endgenerate

    assign w_sel     = CNT_W'(beat_slice(int'(r_beat_cnt), RATIO, MSB_FIRST));
    assign out_data  = w_beats[w_sel];
    assign out_valid = w_cur_vld;
    assign out_last  = w_cur_vld & (r_beat_cnt == LAST_BEAT);
    assign busy      = w_cur_vld | w_nxt_vld | r_inflight;

`ifdef UNPACK_STALL_CNT_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_starve_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt  <= '0;
            r_starve_cnt <= '0;
        end else begin
            if (w_cur_vld && !out_ready && r_stall_cnt != 16'hFFFF) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (!w_cur_vld && out_ready && !busy && fifo_rd_empty && r_starve_cnt != 16'hFFFF) begin
                r_starve_cnt <= r_starve_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign starve_cnt = r_starve_cnt;
`endif

endmodule
`default_nettype wire
